wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
- Two-master to one-slave Wishbone arbiter sharing the external bus between the data-side cache (master 0, memory stage) and the instruction-side cache (master 1, fetch).
- Round-robin grant, held for the full `cyc` burst; slave responses route only to the granted master.
- A watchdog terminates hung transactions with `err` so neither pipeline stage stalls forever.

Parameters:
- TIMEOUT_CYCLES, 256: cycles a strobed slave access may wait for ack/err/rty before forced termination; legal range 2..65535.
- CNT_W, 16: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_adr_i, m1_adr_i  in  32  master address.
- m0_dat_i, m1_dat_i  in  32  master write data.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_sel_i, m1_sel_i  in  4  byte select.
- m0_stb_i, m1_stb_i  in  1  strobe.
- m0_cyc_i, m1_cyc_i  in  1  bus cycle request.
- m0_dat_o, m1_dat_o  out  32  read data (slave data broadcast to both).
- m0_ack_o, m1_ack_o  out  1  ack to master.
- m0_rty_o, m1_rty_o  out  1  retry to master.
- m0_err_o, m1_err_o  out  1  error to master.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_we_o  out  1  slave write enable.
- s_sel_o  out  4  slave byte select.
- s_stb_o  out  1  slave strobe.
- s_cyc_o  out  1  slave cycle.
- s_dat_i  in  32  slave read data.
- s_ack_i, s_rty_i, s_err_i  in  1  slave responses.
- grant_o  out  2  one-hot current grant; 00 = idle.
- timeout_o  out  1  one-cycle pulse on watchdog termination.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (master 0 wins first contention), watchdog=0. All s_* outputs 0; all m*_ack/rty/err 0; grant_o=00; timeout_o=0. Reset mid-transfer abandons it immediately; no response is delivered.
- States:
  - IDLE: no grant.
  - GRANT0: m0 owns the bus.
  - GRANT1: m1 owns the bus.
- Grant is registered. A request first seen at edge N yields grant_o and s_cyc_o asserted after edge N+1 (one-cycle arbitration latency).
- IDLE transitions:
  - Only m0_cyc_i → GRANT0.
  - Only m1_cyc_i → GRANT1.
  - Both → the master not equal to last_grant; update last_grant on entry.
- GRANTx: stays while mx_cyc_i=1. When mx_cyc_i drops:
  - Other master's cyc_i=1 → go directly to GRANT(other), no idle cycle, last_grant updated.
  - Otherwise → IDLE.
- Datapath in GRANTx:
  - s_adr/dat/we/sel/stb/cyc_o = mx inputs (s_cyc_o gated by grant).
  - mx_ack/rty/err_o = s_*_i, combinational.
  - Non-granted master sees ack/rty/err=0.
- In IDLE all s_* outputs are 0.
- m0_dat_o = m1_dat_o = s_dat_i always.
- Slave responses are ignored whenever s_stb_o=0.
- Watchdog:
  - Counts cycles with s_stb_o=1 and no s_ack_i/s_rty_i/s_err_i.
  - Clears on any response, on grant change, and in IDLE.
  - When count == TIMEOUT_CYCLES-1 with no response that cycle: drive mx_err_o=1 and timeout_o=1 for exactly that cycle, force s_stb_o=0 and s_cyc_o=0 that cycle, clear the count.
  - Master then drops cyc and normal release applies.
- Simultaneous events:
  - Slave response in the timeout cycle wins: no forced err, no timeout_o.
  - Release of one master in the same cycle the other raises cyc → direct handover per the rule above.
- Master must hold its request stable while stb=1 and no response; the arbiter does not latch master inputs.

Test Plan:
- Single master: m0 reads 0x8000_0010 with cyc/stb at cycle 0; slave acks at cycle 3 with 0xDEADBEEF → grant_o=01 from cycle 1, s_adr_o=0x8000_0010, m0_ack_o=1 and m0_dat_o=0xDEADBEEF at cycle 3, m1_ack_o=0 throughout.
- Contention after reset: m0 and m1 raise cyc on the same cycle → m0 granted first; after m0 drops cyc, grant_o becomes 10 on the next cycle with no 00 gap.
- Round-robin: both hold requests continuously for 4 back-to-back single-beat transfers → grant order m0, m1, m0, m1.
- Timeout, TIMEOUT_CYCLES=8: m1 strobes and the slave never responds → m1_err_o=1 and timeout_o=1 in exactly the 8th strobed cycle, s_stb_o=0 that cycle; after m1 drops cyc, state returns to IDLE.
- Ack in the timeout cycle, TIMEOUT_CYCLES=8: slave acks in the 8th cycle → m1_ack_o=1, m1_err_o=0, timeout_o=0.
- Reset mid-operation: rst_n pulsed low during GRANT1 with stb high → all outputs 0 immediately (async), grant_o=00; after release with both requesting, m0 is granted.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2m
//   Two-master to one-slave Wishbone arbiter. Master 0 is the data-side cache
//   (memory stage) and master 1 is the instruction-side cache (fetch).
//   Masters are granted round-robin, and a grant is held for the whole cyc
//   burst. Slave responses go only to the granted master. A watchdog ends any
//   strobed access that gets no response within TIMEOUT_CYCLES cycles. It does
//   this by returning err to the master.
//
// Parameters
//   TIMEOUT_CYCLES : strobed cycles allowed before forced termination (2..65535)
//   CNT_W          : watchdog counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   clk, rst_n                    : rising-edge clock, async active-low reset
//   mX_adr/dat/we/sel/stb/cyc_i   : master X request
//   mX_dat/ack/rty/err_o          : master X response
//   s_adr/dat/we/sel/stb/cyc_o    : slave request (from granted master)
//   s_dat/ack/rty/err_i           : slave response
//   grant_o                       : one-hot grant, 00 = idle
//   timeout_o                     : pulse in the cycle the watchdog fires
// -----------------------------------------------------------------------------
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_rty_o,
  output logic        m0_err_o,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_rty_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_rty_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;  // 1: master 0 wins next tie
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [1:0]       grant_q, grant_d;

  logic        sel0, sel1;
  logic        stb_raw, cyc_raw;
  logic        resp;
  logic        wd_fire;

  // Request mux. Everything is forced to zero when no master is granted.
  always_comb begin
    sel0    = (state_q == ST_GRANT0);
    sel1    = (state_q == ST_GRANT1);
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_we_o  = 1'b0;
    s_sel_o = 4'd0;
    stb_raw = 1'b0;
    cyc_raw = 1'b0;
    if (sel0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      stb_raw = m0_stb_i;
      cyc_raw = m0_cyc_i;
    end else if (sel1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      stb_raw = m1_stb_i;
      cyc_raw = m1_cyc_i;
    end
  end

  // Responses are qualified with the unforced strobe. A real slave response
  // in the would-be timeout cycle therefore takes priority over the watchdog.
  assign resp    = stb_raw & (s_ack_i | s_rty_i | s_err_i);
  assign wd_fire = stb_raw & ~resp & (wd_cnt_q == WD_LAST);

  assign s_stb_o   = stb_raw & ~wd_fire;
  assign s_cyc_o   = cyc_raw & ~wd_fire;
  assign timeout_o = wd_fire;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = sel0 & stb_raw & s_ack_i;
  assign m0_rty_o = sel0 & stb_raw & s_rty_i;
  assign m0_err_o = sel0 & ((stb_raw & s_err_i) | wd_fire);
  assign m1_ack_o = sel1 & stb_raw & s_ack_i;
  assign m1_rty_o = sel1 & stb_raw & s_rty_i;
  assign m1_err_o = sel1 & ((stb_raw & s_err_i) | wd_fire);

  assign grant_o = grant_q;

  // Arbitration: the grant is held while the owner keeps cyc high. On release
  // it passes straight to a waiting master, so no idle cycle is inserted.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d      = last_grant_q ? ST_GRANT0 : ST_GRANT1;
          last_grant_d = ~last_grant_q;
        end else if (m0_cyc_i) begin
          state_d      = ST_GRANT0;
          last_grant_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = ST_GRANT1;
          last_grant_d = 1'b1;
        end
      end
      ST_GRANT0: begin
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_d      = ST_GRANT1;
            last_grant_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GRANT1: begin
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_d      = ST_GRANT0;
            last_grant_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    grant_d = {state_d == ST_GRANT1, state_d == ST_GRANT0};

    // The watchdog measures one access by one owner. It restarts on any
    // response, on a firing, on a change of owner, and while idle.
    if (state_q == ST_IDLE || state_d != state_q || resp || wd_fire) begin
      wd_cnt_d = '0;
    end else if (stb_raw) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= '0;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
      grant_q      <= grant_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_2m
//   Bench for wb_arbiter_2m with TIMEOUT_CYCLES = 8. A cycle-level reference
//   model tracks the bus owner, whose turn it is on a tie and how long the
//   current access has waited. Every cycle, each DUT output is compared with
//   the model. Directed scenarios are then followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_wb_arbiter_2m;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic        m_stb [2];
  logic        m_cyc [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_rty_o, m0_err_o;
  logic        m1_ack_o, m1_rty_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_rty_i, s_err_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_we_i(m_we[0]),
    .m0_sel_i(m_sel[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_we_i(m_we[1]),
    .m1_sel_i(m_sel[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_rty_o(m0_rty_o), .m0_err_o(m0_err_o),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_rty_o(m1_rty_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_rty_i(s_rty_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: owner -1 = nobody; tie = master that wins a tie.
  int owner, tie, waited;

  // Expected values for the current cycle.
  logic [31:0] e_sadr, e_sdat;
  logic        e_swe, e_sstb, e_scyc, e_to, e_resp;
  logic [3:0]  e_ssel;
  logic [1:0]  e_grant;
  logic        e_ack [2];
  logic        e_rty [2];
  logic        e_err [2];

  // Last observed DUT values, for directed checks.
  logic [1:0]  o_grant;
  logic [31:0] o_sadr, o_dat0;
  logic        o_ack0, o_ack1, o_err1, o_to, o_sstb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    tie    = 0;
    waited = 0;
  endtask

  task automatic model_outputs();
    logic stb;
    e_sadr = '0; e_sdat = '0; e_swe = 0; e_ssel = '0; e_sstb = 0; e_scyc = 0;
    e_to = 0; e_resp = 0; e_grant = 2'b00;
    for (int i = 0; i < 2; i++) begin
      e_ack[i] = 0; e_rty[i] = 0; e_err[i] = 0;
    end
    if (rst_n && owner >= 0) begin
      stb     = m_stb[owner];
      e_grant = (owner == 0) ? 2'b01 : 2'b10;
      e_resp  = stb && (s_ack_i || s_rty_i || s_err_i);
      e_to    = stb && !e_resp && (waited == T - 1);
      e_sadr  = m_adr[owner];
      e_sdat  = m_dat[owner];
      e_swe   = m_we[owner];
      e_ssel  = m_sel[owner];
      e_sstb  = stb && !e_to;
      e_scyc  = m_cyc[owner] && !e_to;
      e_ack[owner] = stb && s_ack_i;
      e_rty[owner] = stb && s_rty_i;
      e_err[owner] = (stb && s_err_i) || e_to;
    end
  endtask

  task automatic model_advance();
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) nxt = tie;
      else if (m_cyc[0])        nxt = 0;
      else if (m_cyc[1])        nxt = 1;
      else                      nxt = -1;
    end else if (m_cyc[owner])   nxt = owner;
    else if (m_cyc[1 - owner])   nxt = 1 - owner;
    else                         nxt = -1;
    if (nxt >= 0 && nxt != owner) tie = 1 - nxt;
    if (nxt != owner || owner < 0 || e_resp || e_to) waited = 0;
    else if (m_stb[owner])                          waited++;
    owner = nxt;
  endtask

  task automatic compare_all();
    check("grant",   32'(grant_o),   32'(e_grant));
    check("s_adr",   s_adr_o,        e_sadr);
    check("s_dat",   s_dat_o,        e_sdat);
    check("s_we",    32'(s_we_o),    32'(e_swe));
    check("s_sel",   32'(s_sel_o),   32'(e_ssel));
    check("s_stb",   32'(s_stb_o),   32'(e_sstb));
    check("s_cyc",   32'(s_cyc_o),   32'(e_scyc));
    check("m0_ack",  32'(m0_ack_o),  32'(e_ack[0]));
    check("m0_rty",  32'(m0_rty_o),  32'(e_rty[0]));
    check("m0_err",  32'(m0_err_o),  32'(e_err[0]));
    check("m1_ack",  32'(m1_ack_o),  32'(e_ack[1]));
    check("m1_rty",  32'(m1_rty_o),  32'(e_rty[1]));
    check("m1_err",  32'(m1_err_o),  32'(e_err[1]));
    check("m0_dat",  m0_dat_o,       s_dat_i);
    check("m1_dat",  m1_dat_o,       s_dat_i);
    check("timeout", 32'(timeout_o), 32'(e_to));
    o_grant = grant_o; o_sadr = s_adr_o; o_dat0 = m0_dat_o;
    o_ack0 = m0_ack_o; o_ack1 = m1_ack_o; o_err1 = m1_err_o;
    o_to = timeout_o; o_sstb = s_stb_o;
  endtask

  // One clock cycle: check mid-cycle, advance the model at the edge, and
  // return 1 time unit after the edge, ready for new stimulus.
  task automatic tick();
    @(negedge clk);
    model_outputs();
    compare_all();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_we[i] = 0; m_sel[i] = '0;
      m_stb[i] = 0;  m_cyc[i] = 0;
    end
    s_dat_i = '0; s_ack_i = 0; s_rty_i = 0; s_err_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic request(input int i, input logic [31:0] adr);
    m_adr[i] = adr;
    m_dat[i] = $urandom;
    m_we[i]  = 1'($urandom_range(0, 1));
    m_sel[i] = 4'($urandom_range(0, 15));
    m_stb[i] = 1;
    m_cyc[i] = 1;
  endtask

  // A master drops its request after any response. An idle master raises a
  // new one with probability raise_pct percent.
  task automatic masters_react(input int raise_pct);
    for (int i = 0; i < 2; i++) begin
      if (m_cyc[i] && (e_ack[i] || e_err[i] || e_rty[i])) begin
        m_cyc[i] = 0;
        m_stb[i] = 0;
      end else if (!m_cyc[i] && $urandom_range(0, 99) < raise_pct) begin
        request(i, $urandom);
      end
    end
  endtask

  logic [1:0] order [$];
  logic [1:0] prev_grant;

  initial begin
    model_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    check("rst_grant", 32'(grant_o),   32'd0);
    check("rst_cyc",   32'(s_cyc_o),   32'd0);
    check("rst_stb",   32'(s_stb_o),   32'd0);
    check("rst_to",    32'(timeout_o), 32'd0);
    do_reset();

    // Single master read with an ack in cycle 3.
    request(0, 32'h8000_0010);
    m_we[0] = 0;
    tick();
    check("sm_grant_c0", 32'(o_grant), 32'd0);
    tick();
    check("sm_grant_c1", 32'(o_grant), 32'b01);
    check("sm_adr",      o_sadr,       32'h8000_0010);
    tick();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    tick();
    check("sm_ack0", 32'(o_ack0), 32'd1);
    check("sm_dat0", o_dat0,      32'hDEAD_BEEF);
    check("sm_ack1", 32'(o_ack1), 32'd0);
    s_ack_i = 0;
    m_cyc[0] = 0; m_stb[0] = 0;
    tick();
    tick();
    check("sm_idle", 32'(o_grant), 32'd0);

    // Contention straight after reset: m0 first, then a direct handover.
    do_reset();
    request(0, 32'h0000_1000);
    request(1, 32'h0000_2000);
    tick();
    tick();
    check("ct_first", 32'(o_grant), 32'b01);
    m_cyc[0] = 0; m_stb[0] = 0;
    tick();
    check("ct_hold", 32'(o_grant), 32'b01);
    tick();
    check("ct_handover", 32'(o_grant), 32'b10);
    idle_inputs();
    tick();
    tick();

    // Round robin: both masters keep requesting, and the slave acks every beat.
    do_reset();
    s_ack_i = 1;
    request(0, 32'h0000_0100);
    request(1, 32'h0000_0200);
    prev_grant = 2'b00;
    for (int c = 0; c < 20 && order.size() < 4; c++) begin
      tick();
      if (o_grant != prev_grant && o_grant != 2'b00) order.push_back(o_grant);
      prev_grant = o_grant;
      masters_react(100);
    end
    check("rr_count", 32'(order.size()), 32'd4);
    while (order.size() < 4) order.push_back(2'b00);
    check("rr_0", 32'(order[0]), 32'b01);
    check("rr_1", 32'(order[1]), 32'b10);
    check("rr_2", 32'(order[2]), 32'b01);
    check("rr_3", 32'(order[3]), 32'b10);
    idle_inputs();
    tick();
    tick();

    // Watchdog firing on a slave that never answers m1.
    do_reset();
    request(1, 32'h0000_3000);
    tick();
    for (int i = 1; i <= T; i++) begin
      tick();
      if (i < T) check("to_early", 32'(o_to), 32'd0);
    end
    check("to_pulse", 32'(o_to),   32'd1);
    check("to_err1",  32'(o_err1), 32'd1);
    check("to_stb",   32'(o_sstb), 32'd0);
    m_cyc[1] = 0; m_stb[1] = 0;
    tick();
    tick();
    check("to_idle", 32'(o_grant), 32'd0);

    // A slave ack in the would-be timeout cycle wins.
    do_reset();
    request(1, 32'h0000_4000);
    tick();
    for (int i = 1; i < T; i++) tick();
    s_ack_i = 1;
    tick();
    check("ta_ack1", 32'(o_ack1), 32'd1);
    check("ta_err1", 32'(o_err1), 32'd0);
    check("ta_to",   32'(o_to),   32'd0);
    idle_inputs();
    tick();
    tick();

    // Asynchronous reset in GRANT1 with a live strobe and ack.
    do_reset();
    request(1, 32'h0000_5000);
    tick();
    tick();
    check("ar_pre", 32'(o_grant), 32'b10);
    s_ack_i = 1;
    #1;
    rst_n = 0;
    #1;
    check("ar_grant", 32'(grant_o),  32'd0);
    check("ar_stb",   32'(s_stb_o),  32'd0);
    check("ar_cyc",   32'(s_cyc_o),  32'd0);
    check("ar_adr",   s_adr_o,       32'd0);
    check("ar_ack1",  32'(m1_ack_o), 32'd0);
    model_reset();
    s_ack_i = 0;
    request(0, 32'h0000_6000);
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    tick();
    check("ar_m0", 32'(o_grant), 32'b01);
    idle_inputs();
    tick();
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      s_dat_i = $urandom;
      case ($urandom_range(0, 15))
        0, 1, 2: begin s_ack_i = 1; s_err_i = 0; s_rty_i = 0; end
        3:       begin s_ack_i = 0; s_err_i = 1; s_rty_i = 0; end
        4:       begin s_ack_i = 0; s_err_i = 0; s_rty_i = 1; end
        default: begin s_ack_i = 0; s_err_i = 0; s_rty_i = 0; end
      endcase
      tick();
      masters_react(40);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
